// File: rtl/kgp_mult_pkg.sv
// Shared definitions for the KGP-RISC sequential multiplier: state encoding,
// default operand width and the register-bank slots that receive the product.
package kgp_mult_pkg;

  localparam int MULT_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Product halves land in these registers on the multiply write-back path
  localparam int MULT_HI_REG = 19;
  localparam int MULT_LO_REG = 20;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } mult_state_e;

endpackage

// File: rtl/mult_sign_adj.sv
// Conditional two's-complement negation; used both to take operand magnitudes
// and to restore the sign of the final product.
module mult_sign_adj #(
  parameter int N = 32
) (
  input  logic [N-1:0] val_i,
  input  logic         neg_i,
  output logic [N-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + N'(1)) : val_i;

endmodule

// File: rtl/mult_seq_unit.sv
// Shift-add multiplier: WIDTH iterations on operand magnitudes, sign applied
// to the full-width accumulator as the result is registered.
module mult_seq_unit
  import kgp_mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  mult_state_e          state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH:0]       sum_d;
  logic [2*WIDTH-1:0]   res_adj;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     prod_hi_q;
  logic [WIDTH-1:0]     prod_lo_q;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;

  // 0x80000000 maps to itself, which is the correct magnitude read unsigned
  mult_sign_adj #(.N(WIDTH)) u_abs_a (
    .val_i (op_a),
    .neg_i (is_signed & op_a[WIDTH-1]),
    .res_o (abs_a)
  );

  mult_sign_adj #(.N(WIDTH)) u_abs_b (
    .val_i (op_b),
    .neg_i (is_signed & op_b[WIDTH-1]),
    .res_o (abs_b)
  );

  // Carry out of the upper-half add is shifted back into the accumulator MSB
  always_comb begin
    sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
          + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
    acc_d = {sum_d, acc_q[WIDTH-1:1]};
  end

  // Negation operates on the final iteration's value so the result registers
  // on the same edge the counter reaches zero
  mult_sign_adj #(.N(2*WIDTH)) u_prod_neg (
    .val_i (acc_d),
    .neg_i (neg_q),
    .res_o (res_adj)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= abs_a;
            mplier_q <= abs_b;
            neg_q    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= CNT_W'(WIDTH);
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            prod_hi_q <= res_adj[2*WIDTH-1:WIDTH];
            prod_lo_q <= res_adj[WIDTH-1:0];
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign prod_hi = prod_hi_q;
  assign prod_lo = prod_lo_q;

endmodule

// File: tb/tb_mult_seq_unit.sv
// Self-checking bench for mult_seq_unit: directed vector table, hand-written
// busy/reset sequences, and random operands against an arithmetic model.
module tb_mult_seq_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          is_signed;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  prod_hi;
  logic [W-1:0]  prod_lo;

  int            checks = 0;
  int            errors = 0;
  logic [63:0]   prev_prod;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  mult_seq_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // One complete multiply; returns at the negedge of the done cycle
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input string name);
    int lat = 0;
    int busy_cnt = 0;
    logic hold_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; is_signed = s;
    @(posedge clk);
    #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; is_signed = 1'($urandom_range(0, 1));
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (done) break;
      if ({prod_hi, prod_lo} !== prev_prod) hold_ok = 1'b0;
    end
    check({name, " latency"}, 64'(lat), 64'd33);
    check({name, " busy cycles"}, 64'(busy_cnt), 64'd33);
    check({name, " hold"}, 64'(hold_ok), 64'd1);
    check({name, " product"}, {prod_hi, prod_lo}, exp);
    prev_prod = exp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int dones;
    logic [31:0] ra, rb;
    logic        rs;

    tbl[0] = '{32'd3,        32'd5,        1'b0, 64'h0000_0000_0000_000F, "u3x5"};
    tbl[1] = '{32'hFFFFFFF9, 32'd6,        1'b1, 64'hFFFF_FFFF_FFFF_FFD6, "s-7x6"};
    tbl[2] = '{32'hFFFFFFF9, 32'd6,        1'b0, 64'h0000_0005_FFFF_FFD6, "u-7x6"};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "umaxsq"};
    tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000_0000_0000_0001, "sm1sq"};
    tbl[5] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000_0000_0000_0000, "sminsq"};
    tbl[6] = '{32'd0,        32'h12345678, 1'b0, 64'h0000_0000_0000_0000, "zero"};

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", {prod_hi, prod_lo}, 64'd0);
    rst = 1'b0;
    prev_prod = 64'd0;

    for (int i = 0; i < 7; i++) begin
      do_mult(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp, tbl[i].name);
      @(negedge clk);
      check({tbl[i].name, " done width"}, 64'(done), 64'd0);
      check({tbl[i].name, " idle busy"}, 64'(busy), 64'd0);
    end

    // start re-asserted during RUN and in the DONE cycle must be ignored
    @(negedge clk);
    start = 1'b1; op_a = 32'd3; op_b = 32'd5; is_signed = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0; op_a = 32'd7; op_b = 32'd7;
    lat = 0; dones = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (done) begin
        dones++;
        start = 1'b1;
        break;
      end
      start = (lat == 1 || lat == 10);
    end
    check("busy-start latency", 64'(lat), 64'd33);
    check("busy-start product", {prod_hi, prod_lo}, 64'd15);
    check("busy-start dones", 64'(dones), 64'd1);
    prev_prod = 64'd15;
    @(posedge clk);
    #1;
    start = 1'b0;
    do_mult(32'd7, 32'd7, 1'b0, 64'd49, "b2b 7x7");

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; op_a = 32'd9; op_b = 32'd9; is_signed = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrun rst busy", 64'(busy), 64'd0);
    check("midrun rst done", 64'(done), 64'd0);
    check("midrun rst product", {prod_hi, prod_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_prod = 64'd0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("post-rst quiet", 64'(dones), 64'd0);
    do_mult(32'd2, 32'd4, 1'b0, 64'd8, "post-rst 2x4");

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'd0;
        default: ;
      endcase
      rs = 1'($urandom_range(0, 1));
      do_mult(ra, rb, rs, ref_mul(ra, rb, rs), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
